spram_fifo_ctrl: RTL and testbench

Stream-to-RAM FIFO controller that sits directly upstream and downstream of one `spram_9x4096` instance. It accepts a valid/ready write stream and drives the RAM write port (`wce/wa/wd`). It drives the RAM read port (`rce/ra`), absorbs the RAM's one-cycle read latency, and presents a valid/ready output stream at full throughput. The RAM stays a separate instance; this block owns all pointers, occupancy and flow control.

---
 rtl/spram_fifo_pkg.sv | 13 +
 rtl/spram_fifo_skid.sv | 73 +++++++
 rtl/spram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_spram_fifo_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_fifo_pkg.sv
// Shared constants and helpers for the spram-backed stream FIFO controller.
package spram_fifo_pkg;

    localparam int DEF_AWIDTH = 12;
    localparam int DEF_DWIDTH = 9;
    localparam int SKID_DEPTH = 2;

    // Largest occupancy: every RAM word plus a full skid buffer.
    function automatic int max_count(input int awidth);
        return (32'sd1 <<< awidth) + SKID_DEPTH;
    endfunction

endpackage

// File: rtl/spram_fifo_skid.sv
// Two-entry output skid buffer; entry0 is always the oldest word and feeds out_data.
module spram_fifo_skid
    import spram_fifo_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [DWIDTH-1:0] entry0_r;
    logic [DWIDTH-1:0] entry1_r;
    logic [1:0]        occ_r;
    logic              pop_s;

    // Handshake decode and output view of the oldest entry.
    always_comb begin
        out_valid = (occ_r != 2'd0);
        pop_s     = out_valid & out_ready;
        out_data  = entry0_r;
        occupancy = occ_r;
    end

    // Entry storage and occupancy; push+pop in the same cycle keeps FIFO order.
    always_ff @(posedge clock0) begin
        if (reset) begin
            entry0_r <= {DWIDTH{1'b0}};
            entry1_r <= {DWIDTH{1'b0}};
            occ_r    <= 2'd0;
        end else begin
            case (occ_r)
                2'd0: begin
                    if (push) begin
                        entry0_r <= push_data;
                        occ_r    <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop_s})
                        2'b11: entry0_r <= push_data;
                        2'b01: occ_r <= 2'd0;
                        2'b10: begin
                            entry1_r <= push_data;
                            occ_r    <= 2'd2;
                        end
                        default: occ_r <= occ_r;
                    endcase
                end
                2'd2: begin
                    case ({push, pop_s})
                        2'b11: begin
                            entry0_r <= entry1_r;
                            entry1_r <= push_data;
                        end
                        2'b01: begin
                            entry0_r <= entry1_r;
                            occ_r    <= 2'd1;
                        end
                        default: occ_r <= occ_r;
                    endcase
                end
                default: occ_r <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// Stream FIFO controller around an external single-port-pair RAM: owns pointers,
// occupancy and read issue, and hides the RAM's one-cycle read latency behind a skid.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int RAM_ID = 0
) (
    input  logic              clock0,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH+1:0] count,
    output logic              full,
    output logic              empty,
    output logic              ram_wce,
    output logic [AWIDTH-1:0] ram_wa,
    output logic [DWIDTH-1:0] ram_wd,
    output logic              ram_rce,
    output logic [AWIDTH-1:0] ram_ra,
    input  logic [DWIDTH-1:0] ram_rq,
    output logic              ram_id
);

    localparam logic [AWIDTH:0]   RAM_FULL_C  = (AWIDTH+1)'(32'd1 << AWIDTH);
    localparam logic [AWIDTH+1:0] MAX_COUNT_C = (AWIDTH+2)'(max_count(AWIDTH));

    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [AWIDTH:0]   ram_cnt_r;
    logic              inflight_r;
    logic              wr_fire_s;
    logic              rd_issue_s;
    logic              pop_s;
    logic [1:0]        skid_occ_s;
    logic [2:0]        credit_s;
    logic [2:0]        limit_s;

    // Write port and read issue; a pop this cycle frees a skid slot so the
    // stream can run at one word per cycle.
    always_comb begin
        in_ready  = (ram_cnt_r != RAM_FULL_C);
        wr_fire_s = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        credit_s  = 3'(skid_occ_s) + 3'(inflight_r);
        limit_s   = 3'd2 + 3'(pop_s);
        if ((ram_cnt_r != {(AWIDTH+1){1'b0}}) && (credit_s < limit_s)) begin
            rd_issue_s = 1'b1;
        end else begin
            rd_issue_s = 1'b0;
        end
        ram_wce = wr_fire_s;
        ram_wa  = wr_ptr_r;
        ram_wd  = in_data;
        ram_rce = rd_issue_s;
        ram_ra  = rd_ptr_r;
        ram_id  = 1'(RAM_ID);
    end

    // Occupancy flags cover RAM, the in-flight read and the skid entries.
    always_comb begin
        count = {1'b0, ram_cnt_r} + (AWIDTH+2)'(inflight_r) + (AWIDTH+2)'(skid_occ_s);
        full  = (count == MAX_COUNT_C);
        empty = (count == {(AWIDTH+2){1'b0}});
    end

    // Pointers, RAM word count and the one-cycle read-in-flight marker.
    always_ff @(posedge clock0) begin
        if (reset) begin
            wr_ptr_r   <= {AWIDTH{1'b0}};
            rd_ptr_r   <= {AWIDTH{1'b0}};
            ram_cnt_r  <= {(AWIDTH+1){1'b0}};
            inflight_r <= 1'b0;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AWIDTH'(1'b1);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= rd_ptr_r + AWIDTH'(1'b1);
            end
            inflight_r <= rd_issue_s;
            case ({wr_fire_s, rd_issue_s})
                2'b10:   ram_cnt_r <= ram_cnt_r + (AWIDTH+1)'(1'b1);
                2'b01:   ram_cnt_r <= ram_cnt_r - (AWIDTH+1)'(1'b1);
                default: ram_cnt_r <= ram_cnt_r;
            endcase
        end
    end

    spram_fifo_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clock0    (clock0),
        .reset     (reset),
        .push      (inflight_r),
        .push_data (ram_rq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (skid_occ_s)
    );

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl: a default-size instance and a 16-deep instance,
// each connected to a behavioural RAM with one-cycle read latency.
module tb_spram_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
    logic        a_wce, a_rce, a_id;
    logic [8:0]  a_in_data, a_out_data, a_wd, a_rq;
    logic [13:0] a_count;
    logic [11:0] a_wa, a_ra;
    logic [8:0]  a_mem [0:4095];
    logic [8:0]  qa [$];

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
    logic        b_wce, b_rce, b_id;
    logic [8:0]  b_in_data, b_out_data, b_wd, b_rq;
    logic [5:0]  b_count;
    logic [3:0]  b_wa, b_ra;
    logic [8:0]  b_mem [0:15];
    logic [8:0]  qb [$];

    spram_fifo_ctrl dut_a (
        .clock0(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .full(a_full), .empty(a_empty),
        .ram_wce(a_wce), .ram_wa(a_wa), .ram_wd(a_wd),
        .ram_rce(a_rce), .ram_ra(a_ra), .ram_rq(a_rq), .ram_id(a_id)
    );

    spram_fifo_ctrl #(.AWIDTH(4), .DWIDTH(9), .RAM_ID(1)) dut_b (
        .clock0(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .full(b_full), .empty(b_empty),
        .ram_wce(b_wce), .ram_wa(b_wa), .ram_wd(b_wd),
        .ram_rce(b_rce), .ram_ra(b_ra), .ram_rq(b_rq), .ram_id(b_id)
    );

    always @(posedge clk) begin
        if (a_wce) a_mem[a_wa] <= a_wd;
        if (a_rce) a_rq <= a_mem[a_ra];
        if (b_wce) b_mem[b_wa] <= b_wd;
        if (b_rce) b_rq <= b_mem[b_ra];
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 9'h000; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 9'h000; b_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", a_out_valid); end
        total++; if (a_out_data !== 9'h000) begin bad++; $display("FAIL rst_out_data got=%h exp=000", a_out_data); end
        total++; if (a_wce !== 1'b0 || a_rce !== 1'b0) begin bad++; $display("FAIL rst_ce got=%b%b exp=00", a_wce, a_rce); end
        total++; if (a_wa !== 12'h000 || a_ra !== 12'h000) begin bad++; $display("FAIL rst_addr got=%h/%h exp=0/0", a_wa, a_ra); end
        total++; if (a_count !== 14'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a_count); end
        total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("FAIL rst_flags got=e%b f%b exp=e1 f0", a_empty, a_full); end
        total++; if (a_id !== 1'b0 || b_id !== 1'b1) begin bad++; $display("FAIL ram_id got=%b/%b exp=0/1", a_id, b_id); end
        total++; if (b_count !== 6'd0 || b_empty !== 1'b1) begin bad++; $display("FAIL rst_b got=%0d/%b exp=0/1", b_count, b_empty); end
    endtask

    task automatic test_single_write();
        do_reset();
        a_in_valid = 1'b1; a_in_data = 9'h1A5; a_out_ready = 1'b0;
        #1;
        total++; if (a_wce !== 1'b1 || a_wa !== 12'h000 || a_wd !== 9'h1A5) begin
            bad++; $display("FAIL single_wr got=wce%b wa%h wd%h exp=wce1 wa000 wd1a5", a_wce, a_wa, a_wd); end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total++; if (a_rce !== 1'b1 || a_ra !== 12'h000) begin bad++; $display("FAIL single_rce got=%b ra%h exp=1 ra000", a_rce, a_ra); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_early1 got=%b exp=0", a_out_valid); end
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_early2 got=%b exp=0", a_out_valid); end
        @(negedge clk);
        total++; if (a_out_valid !== 1'b1 || a_out_data !== 9'h1A5) begin
            bad++; $display("FAIL single_out got=v%b d%h exp=v1 d1a5", a_out_valid, a_out_data); end
        total++; if (a_count !== 14'd1 || a_empty !== 1'b0) begin bad++; $display("FAIL single_count got=%0d exp=1", a_count); end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        #1;
        total++; if (a_empty !== 1'b1 || a_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=e%b v%b exp=e1 v0", a_empty, a_out_valid); end
    endtask

    task automatic test_stream();
        int   sent = 0;
        int   got = 0;
        bit   started = 1'b0;
        logic [8:0] exp_d;
        do_reset();
        for (int cyc = 0; cyc < 300 && got < 64; cyc++) begin
            @(negedge clk);
            a_in_valid  = (sent < 64);
            a_in_data   = 9'($urandom);
            a_out_ready = 1'b1;
            #1;
            if (a_in_valid && a_in_ready) begin qa.push_back(a_in_data); sent++; end
            if (a_out_valid) begin
                started = 1'b1;
                exp_d = (qa.size() != 0) ? qa.pop_front() : 9'h000;
                total++; if (a_out_data !== exp_d) begin bad++; $display("FAIL stream_data idx=%0d got=%h exp=%h", got, a_out_data, exp_d); end
                got++;
            end else if (started) begin
                total++; bad++; $display("FAIL stream_gap idx=%0d got=valid0 exp=valid1", got);
            end
        end
        a_in_valid = 1'b0;
        total++; if (got != 64) begin bad++; $display("FAIL stream_count got=%0d exp=64", got); end
    endtask

    task automatic test_back_pressure();
        int got = 0;
        logic [8:0] exp_d;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_data = 9'(9'h100 + i);
            #1;
            if (a_in_ready) qa.push_back(a_in_data);
            total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready i=%0d got=0 exp=1", i); end
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (a_count !== 14'd10) begin bad++; $display("FAIL bp_count got=%0d exp=10", a_count); end
        total++; if (dut_a.ram_cnt_r !== 13'd8) begin bad++; $display("FAIL bp_ram_cnt got=%0d exp=8", dut_a.ram_cnt_r); end
        total++; if (dut_a.u_skid.occ_r !== 2'd2) begin bad++; $display("FAIL bp_skid got=%0d exp=2", dut_a.u_skid.occ_r); end
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            a_out_ready = 1'b1;
            #1;
            if (a_out_valid) begin
                exp_d = (qa.size() != 0) ? qa.pop_front() : 9'h000;
                total++; if (a_out_data !== exp_d) begin bad++; $display("FAIL bp_data idx=%0d got=%h exp=%h", got, a_out_data, exp_d); end
                got++;
            end else begin
                total++; bad++; $display("FAIL bp_gap idx=%0d got=valid0 exp=valid1", got);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b0;
        total++; if (got != 10 || a_empty !== 1'b1) begin bad++; $display("FAIL bp_drain got=%0d e%b exp=10 e1", got, a_empty); end
    endtask

    task automatic test_fill();
        bit ok = 1'b0;
        int got = 0;
        logic [8:0] exp_d;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_data = 9'(i + 1);
            #1;
            if (b_in_ready) qb.push_back(b_in_data);
            total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready i=%0d got=0 exp=1", i); end
        end
        @(negedge clk);
        b_in_data = 9'h1FF;
        #1;
        total++; if (b_full !== 1'b1 || b_in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=f%b r%b exp=f1 r0", b_full, b_in_ready); end
        total++; if (b_count !== 6'd18) begin bad++; $display("FAIL fill_count got=%0d exp=18", b_count); end
        total++; if (b_wce !== 1'b0) begin bad++; $display("FAIL fill_wce got=%b exp=0", b_wce); end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        total++; if (b_count !== 6'd18) begin bad++; $display("FAIL fill_19th got=%0d exp=18", b_count); end
        b_out_ready = 1'b1;
        #1;
        exp_d = (qb.size() != 0) ? qb.pop_front() : 9'h000;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== exp_d) begin bad++; $display("FAIL fill_pop got=v%b %h exp=v1 %h", b_out_valid, b_out_data, exp_d); end
        @(negedge clk);
        b_out_ready = 1'b0;
        for (int k = 0; k < 2 && !ok; k++) begin
            #1;
            if (b_in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL fill_reopen got=in_ready0 exp=in_ready1"); end
        @(negedge clk);
        for (int cyc = 0; cyc < 60 && got < 17; cyc++) begin
            b_out_ready = 1'b1;
            #1;
            if (b_out_valid) begin
                exp_d = (qb.size() != 0) ? qb.pop_front() : 9'h000;
                total++; if (b_out_data !== exp_d) begin bad++; $display("FAIL fill_data idx=%0d got=%h exp=%h", got, b_out_data, exp_d); end
                got++;
            end
            @(negedge clk);
        end
        b_out_ready = 1'b0;
        #1;
        total++; if (got != 17 || b_empty !== 1'b1) begin bad++; $display("FAIL fill_drain got=%0d e%b exp=17 e1", got, b_empty); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        logic [3:0] exp_wa = 4'd0;
        logic [3:0] exp_ra = 4'd0;
        bit wa_wrap = 1'b0;
        bit ra_wrap = 1'b0;
        logic [8:0] exp_d;
        do_reset();
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            @(negedge clk);
            b_in_valid  = (sent < 100) && (cyc % 5 != 3);
            b_in_data   = 9'($urandom);
            b_out_ready = ((cyc % 11) < 7);
            #1;
            total++; if (b_wce !== (b_in_valid && b_in_ready)) begin bad++; $display("FAIL wrap_wce cyc=%0d got=%b", cyc, b_wce); end
            if (b_in_valid && b_in_ready) begin
                total++; if (b_wa !== exp_wa) begin bad++; $display("FAIL wrap_wa got=%0d exp=%0d", b_wa, exp_wa); end
                if (exp_wa == 4'd15) wa_wrap = 1'b1;
                exp_wa = exp_wa + 4'd1;
                qb.push_back(b_in_data);
                sent++;
            end
            if (b_rce) begin
                total++; if (b_ra !== exp_ra) begin bad++; $display("FAIL wrap_ra got=%0d exp=%0d", b_ra, exp_ra); end
                if (exp_ra == 4'd15) ra_wrap = 1'b1;
                exp_ra = exp_ra + 4'd1;
            end
            if (b_out_valid && b_out_ready) begin
                exp_d = (qb.size() != 0) ? qb.pop_front() : 9'h000;
                total++; if (b_out_data !== exp_d) begin bad++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", got, b_out_data, exp_d); end
                got++;
            end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        total++; if (got != 100) begin bad++; $display("FAIL wrap_count got=%0d exp=100", got); end
        total++; if (!wa_wrap || !ra_wrap) begin bad++; $display("FAIL wrap_seen got=wa%b ra%b exp=wa1 ra1", wa_wrap, ra_wrap); end
    endtask

    task automatic test_reset_midop();
        bit seen = 1'b0;
        logic [8:0] exp_d;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_data = 9'(9'h0A0 + i);
            #1;
            if (a_in_ready) qa.push_back(a_in_data);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            #1;
            exp_d = (qa.size() != 0) ? qa.pop_front() : 9'h000;
            total++; if (a_out_valid !== 1'b1 || a_out_data !== exp_d) begin bad++; $display("FAIL mid_pop p=%0d got=%h exp=%h", p, a_out_data, exp_d); end
        end
        @(negedge clk);
        a_out_ready = 1'b0;
        #1;
        total++; if (a_count !== 14'd5 || dut_a.inflight_r !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=cnt%0d inf%b exp=cnt5 inf1", a_count, dut_a.inflight_r); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        qa.delete();
        #1;
        total++; if (a_count !== 14'd0 || a_out_valid !== 1'b0 || a_empty !== 1'b1) begin
            bad++; $display("FAIL mid_reset got=cnt%0d v%b e%b exp=cnt0 v0 e1", a_count, a_out_valid, a_empty); end
        a_in_valid = 1'b1; a_in_data = 9'h055;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            #1;
            if (a_out_valid) begin
                seen = 1'b1;
                total++; if (a_out_data !== 9'h055) begin bad++; $display("FAIL mid_readback got=%h exp=055", a_out_data); end
            end
            @(negedge clk);
        end
        a_out_ready = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL mid_timeout got=no_output exp=055"); end
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 9'h000; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 9'h000; b_out_ready = 1'b0;
        test_reset();
        test_single_write();
        test_stream();
        test_back_pressure();
        test_fill();
        test_wrap();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
